// File: rtl/psr_branch_unit_if.sv
// Execute-stage to PSR/branch unit interface: flag updates, PSR load/read,
// interrupt shadow control and the branch decision returned to fetch.
interface psr_branch_unit_if #(
   parameter int unsigned REGBITS  = 5,
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned CONDBITS = 4
);
   logic                en;
   logic [REGBITS-1:0]  flag_in;
   logic [REGBITS-1:0]  flag_we;
   logic                psr_wr;
   logic [WIDTH-1:0]    psr_wdata;
   logic                psr_save;
   logic                psr_restore;
   logic                cond_eval;
   logic [CONDBITS-1:0] cond;
   logic [REGBITS-1:0]  psr;
   logic [WIDTH-1:0]    psr_rdata;
   logic                branch_taken;
   logic                branch_valid;

   modport master (
      output en, flag_in, flag_we, psr_wr, psr_wdata, psr_save, psr_restore,
             cond_eval, cond,
      input  psr, psr_rdata, branch_taken, branch_valid
   );

   modport slave (
      input  en, flag_in, flag_we, psr_wr, psr_wdata, psr_save, psr_restore,
             cond_eval, cond,
      output psr, psr_rdata, branch_taken, branch_valid
   );
endinterface

// File: rtl/psr_branch_unit.sv
// Program Status Register with per-flag write masks, one-entry interrupt shadow,
// and registered branch-condition evaluation against the bypassed next PSR.
module psr_branch_unit #(
   parameter int unsigned REGBITS  = 5,
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned CONDBITS = 4
) (
   input  logic             clk,
   input  logic             reset,
   psr_branch_unit_if.slave bus
);
   // Flag positions inside {C,L,F,Z,N}
   localparam int unsigned N_BIT = 0;
   localparam int unsigned Z_BIT = 1;
   localparam int unsigned F_BIT = 2;
   localparam int unsigned L_BIT = 3;
   localparam int unsigned C_BIT = 4;

   logic [REGBITS-1:0] r_psr;
   logic [REGBITS-1:0] r_shadow;
   logic               r_branch_taken;
   logic               r_branch_valid;
   logic [REGBITS-1:0] w_psr_next;
   logic               w_taken;
   logic               w_unused_wdata;

   // Next PSR: restore beats explicit load beats masked flag update
   always_comb begin
      w_psr_next = r_psr;
      if (bus.psr_restore) begin
         w_psr_next = r_shadow;
      end else if (bus.psr_wr) begin
         w_psr_next = bus.psr_wdata[REGBITS-1:0];
      end else begin
         w_psr_next = (bus.flag_we & bus.flag_in) | (~bus.flag_we & r_psr);
      end
   end

   // Condition decode on the bypassed value so a fused compare-and-branch sees its own flags
   always_comb begin
      w_taken = 1'b0;
      case (bus.cond)
         4'b0000: w_taken =  w_psr_next[Z_BIT];
         4'b0001: w_taken = ~w_psr_next[Z_BIT];
         4'b0010: w_taken =  w_psr_next[C_BIT];
         4'b0011: w_taken = ~w_psr_next[C_BIT];
         4'b0100: w_taken =  w_psr_next[L_BIT];
         4'b0101: w_taken = ~w_psr_next[L_BIT];
         4'b0110: w_taken =  w_psr_next[N_BIT];
         4'b0111: w_taken = ~w_psr_next[N_BIT];
         4'b1000: w_taken =  w_psr_next[F_BIT];
         4'b1001: w_taken = ~w_psr_next[F_BIT];
         4'b1010: w_taken = ~w_psr_next[L_BIT] & ~w_psr_next[Z_BIT];
         4'b1011: w_taken =  w_psr_next[L_BIT] |  w_psr_next[Z_BIT];
         4'b1100: w_taken = ~w_psr_next[N_BIT] & ~w_psr_next[Z_BIT];
         4'b1101: w_taken =  w_psr_next[N_BIT] |  w_psr_next[Z_BIT];
         4'b1110: w_taken = 1'b1;
         default: w_taken = 1'b0;
      endcase
   end

   // Shadow always captures the pre-update PSR, which makes save+restore a swap
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_psr          <= '0;
         r_shadow       <= '0;
         r_branch_taken <= 1'b0;
         r_branch_valid <= 1'b0;
      end else if (bus.en) begin
         r_psr          <= w_psr_next;
         r_branch_valid <= bus.cond_eval;
         if (bus.psr_save) begin
            r_shadow <= r_psr;
         end
         if (bus.cond_eval) begin
            r_branch_taken <= w_taken;
         end
      end else begin
         r_branch_valid <= 1'b0;
      end
   end

   assign w_unused_wdata   = ^bus.psr_wdata[WIDTH-1:REGBITS];
   assign bus.psr          = r_psr;
   assign bus.psr_rdata    = {{(WIDTH-REGBITS){1'b0}}, r_psr};
   assign bus.branch_taken = r_branch_taken;
   assign bus.branch_valid = r_branch_valid;
endmodule

// File: tb/tb_psr_branch_unit.sv
// Directed self-checking bench for psr_branch_unit.
module tb_psr_branch_unit;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   psr_branch_unit_if #(.REGBITS(5), .WIDTH(32), .CONDBITS(4)) bus ();

   psr_branch_unit #(.REGBITS(5), .WIDTH(32), .CONDBITS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_idle();
      bus.en          = 1'b1;
      bus.flag_in     = '0;
      bus.flag_we     = '0;
      bus.psr_wr      = 1'b0;
      bus.psr_wdata   = '0;
      bus.psr_save    = 1'b0;
      bus.psr_restore = 1'b0;
      bus.cond_eval   = 1'b0;
      bus.cond        = '0;
   endtask

   // Drive at negedge, one rising edge, observe at the following negedge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_psr(input logic [4:0] v);
      set_idle();
      bus.psr_wr    = 1'b1;
      bus.psr_wdata = 32'(v);
      step();
      set_idle();
   endtask

   task automatic test_reset();
      load_psr(5'b11111);
      bus.cond_eval = 1'b1;
      bus.cond      = 4'b1110;
      step();
      checks++;
      if (bus.psr !== 5'b11111 || bus.branch_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre psr=%b valid=%b expected psr=11111 valid=1", bus.psr, bus.branch_valid);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (bus.psr !== 5'b00000 || bus.branch_valid !== 1'b0 || bus.branch_taken !== 1'b0) begin
         errors++;
         $display("FAIL reset_async psr=%b valid=%b taken=%b expected 00000/0/0",
                  bus.psr, bus.branch_valid, bus.branch_taken);
      end
      @(negedge clk);
      reset = 1'b1;
      set_idle();
      bus.psr_wr    = 1'b1;
      bus.psr_wdata = 32'hFFFF_FFF5;
      step();
      checks++;
      if (bus.psr !== 5'b10101 || bus.psr_rdata !== 32'h0000_0015) begin
         errors++;
         $display("FAIL lpr psr=%b rdata=%h expected 10101/00000015", bus.psr, bus.psr_rdata);
      end
      set_idle();
   endtask

   task automatic test_masked_update();
      load_psr(5'b00000);
      bus.flag_in = 5'b11111;
      bus.flag_we = 5'b01011;
      step();
      checks++;
      if (bus.psr !== 5'b01011) begin
         errors++;
         $display("FAIL masked_update psr=%b expected 01011", bus.psr);
      end
      bus.flag_we = 5'b00000;
      step();
      checks++;
      if (bus.psr !== 5'b01011) begin
         errors++;
         $display("FAIL masked_hold psr=%b expected 01011", bus.psr);
      end
      bus.flag_we   = 5'b11111;
      bus.flag_in   = 5'b11111;
      bus.psr_wr    = 1'b1;
      bus.psr_wdata = 32'h0000_002A;
      step();
      checks++;
      if (bus.psr !== 5'b01010 || bus.psr_rdata !== 32'h0000_000A) begin
         errors++;
         $display("FAIL lpr_over_flags psr=%b rdata=%h expected 01010/0000000a", bus.psr, bus.psr_rdata);
      end
      set_idle();
   endtask

   task automatic test_fused_branch();
      load_psr(5'b00000);
      bus.flag_in   = 5'b00010;
      bus.flag_we   = 5'b01011;
      bus.cond_eval = 1'b1;
      bus.cond      = 4'b0001;
      step();
      checks++;
      if (bus.branch_valid !== 1'b1 || bus.branch_taken !== 1'b0 || bus.psr !== 5'b00010) begin
         errors++;
         $display("FAIL fused_ne valid=%b taken=%b psr=%b expected 1/0/00010",
                  bus.branch_valid, bus.branch_taken, bus.psr);
      end
      load_psr(5'b00000);
      bus.flag_in   = 5'b00010;
      bus.flag_we   = 5'b01011;
      bus.cond_eval = 1'b1;
      bus.cond      = 4'b0000;
      step();
      checks++;
      if (bus.branch_valid !== 1'b1 || bus.branch_taken !== 1'b1) begin
         errors++;
         $display("FAIL fused_eq valid=%b taken=%b expected 1/1", bus.branch_valid, bus.branch_taken);
      end
      set_idle();
      step();
      checks++;
      if (bus.branch_valid !== 1'b0 || bus.branch_taken !== 1'b1) begin
         errors++;
         $display("FAIL taken_hold valid=%b taken=%b expected 0/1", bus.branch_valid, bus.branch_taken);
      end
   endtask

   // Back-to-back evaluations of every condition code against three PSR values
   task automatic test_cond_table();
      logic [4:0]  psr_v [3];
      logic [15:0] exp_v [3];
      logic [15:0] ev;
      psr_v[0] = 5'b00000; exp_v[0] = 16'h56AA;
      psr_v[1] = 5'b11111; exp_v[1] = 16'h6955;
      psr_v[2] = 5'b01000; exp_v[2] = 16'h5A9A;
      for (int p = 0; p < 3; p++) begin
         load_psr(psr_v[p]);
         ev = exp_v[p];
         for (int c = 0; c < 16; c++) begin
            bus.cond_eval = 1'b1;
            bus.cond      = 4'(c);
            step();
            checks++;
            if (bus.branch_valid !== 1'b1 || bus.branch_taken !== ev[c]) begin
               errors++;
               $display("FAIL cond psr=%b cond=%0d valid=%b taken=%b expected 1/%b",
                        psr_v[p], c, bus.branch_valid, bus.branch_taken, ev[c]);
            end
         end
         set_idle();
      end
   endtask

   task automatic test_save_restore();
      load_psr(5'b10001);
      bus.psr_save = 1'b1;
      bus.flag_we  = 5'b11111;
      bus.flag_in  = 5'b00000;
      step();
      checks++;
      if (bus.psr !== 5'b00000) begin
         errors++;
         $display("FAIL save_update psr=%b expected 00000", bus.psr);
      end
      set_idle();
      step();
      bus.psr_restore = 1'b1;
      step();
      checks++;
      if (bus.psr !== 5'b10001) begin
         errors++;
         $display("FAIL restore psr=%b expected 10001", bus.psr);
      end
      load_psr(5'b11000);
      bus.psr_save = 1'b1;
      step();
      load_psr(5'b00011);
      bus.psr_save    = 1'b1;
      bus.psr_restore = 1'b1;
      step();
      checks++;
      if (bus.psr !== 5'b11000) begin
         errors++;
         $display("FAIL swap_psr psr=%b expected 11000", bus.psr);
      end
      set_idle();
      bus.psr_restore = 1'b1;
      bus.psr_wr      = 1'b1;
      bus.psr_wdata   = 32'h0000_001F;
      bus.flag_we     = 5'b11111;
      step();
      checks++;
      if (bus.psr !== 5'b00011) begin
         errors++;
         $display("FAIL swap_shadow psr=%b expected 00011", bus.psr);
      end
      set_idle();
   endtask

   task automatic test_stall();
      load_psr(5'b00101);
      bus.cond_eval = 1'b1;
      bus.cond      = 4'b1110;
      bus.psr_save  = 1'b1;
      step();
      load_psr(5'b11110);
      bus.en          = 1'b0;
      bus.psr_wr      = 1'b1;
      bus.psr_wdata   = 32'h0000_0001;
      bus.psr_save    = 1'b1;
      bus.flag_we     = 5'b11111;
      bus.cond_eval   = 1'b1;
      bus.cond        = 4'b1111;
      step();
      checks++;
      if (bus.psr !== 5'b11110 || bus.branch_taken !== 1'b1 || bus.branch_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall psr=%b taken=%b valid=%b expected 11110/1/0",
                  bus.psr, bus.branch_taken, bus.branch_valid);
      end
      set_idle();
      bus.psr_restore = 1'b1;
      step();
      checks++;
      if (bus.psr !== 5'b00101) begin
         errors++;
         $display("FAIL stall_shadow psr=%b expected 00101", bus.psr);
      end
      set_idle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      set_idle();
      @(negedge clk);
      checks++;
      if (bus.psr !== 5'b00000 || bus.branch_valid !== 1'b0 || bus.branch_taken !== 1'b0
          || bus.psr_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_state psr=%b valid=%b taken=%b rdata=%h expected zeros",
                  bus.psr, bus.branch_valid, bus.branch_taken, bus.psr_rdata);
      end
      @(negedge clk);
      reset = 1'b1;
      test_reset();
      test_masked_update();
      test_fused_branch();
      test_cond_table();
      test_save_restore();
      test_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/psr_branch_unit.md
Name: psr_branch_unit

Overview:
- Sits directly downstream of the execute-stage ALU and consumes its 5-bit flag vector {C,L,F,Z,N}.
- Holds the architectural Program Status Register (PSR) with per-flag write masks.
- Keeps a one-entry shadow copy for interrupt entry/return and supports explicit PSR load/read (LPR/SPR).
- Evaluates 4-bit branch condition codes against the PSR and registers a taken/not-taken decision for the fetch stage.

Parameters:
- REGBITS, 5, PSR width; bit order {C,L,F,Z,N} = [4:0].
- WIDTH, 32, datapath width for PSR load/read.
- CONDBITS, 4, condition-code field width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  pipeline advance; 0 freezes all state.
- flag_in  input  REGBITS  ALU flag vector {C,L,F,Z,N}.
- flag_we  input  REGBITS  per-flag write mask from controller; bit i=1 updates PSR[i] from flag_in[i].
- psr_wr  input  1  LPR: load PSR from psr_wdata[REGBITS-1:0].
- psr_wdata  input  WIDTH  LPR source (Rs value).
- psr_save  input  1  interrupt entry: copy PSR to shadow.
- psr_restore  input  1  interrupt return: copy shadow to PSR.
- cond_eval  input  1  branch/Scond in execute this cycle.
- cond  input  CONDBITS  condition code.
- psr  output  REGBITS  current registered PSR.
- psr_rdata  output  WIDTH  SPR read: PSR zero-extended to WIDTH, combinational from psr.
- branch_taken  output  1  registered decision.
- branch_valid  output  1  registered; 1 for one cycle after an accepted cond_eval.

Behaviour:
- Reset (reset=0, asynchronous): psr=0, shadow=0, branch_taken=0, branch_valid=0. Takes effect immediately, including mid-operation; a pending evaluation is discarded.
- en=0: psr, shadow and branch_taken hold their values; branch_valid is forced to 0 on that edge; all inputs are ignored.
- psr_next priority, highest first:
  - psr_restore: psr_next = shadow.
  - psr_wr: psr_next = psr_wdata[REGBITS-1:0].
  - Otherwise: psr_next[i] = flag_we[i] ? flag_in[i] : psr[i].
  - flag_we=0 leaves psr unchanged.
- Shadow: on psr_save, shadow <= psr, the pre-update value, not psr_next.
- psr_save and psr_restore in the same cycle swap the two: psr <= old shadow, shadow <= old psr.
- psr_save combined with psr_wr or a flag update: shadow gets the old psr, and psr gets the new value.
- Condition evaluation uses the bypassed value psr_next, so flags written by the same-cycle instruction are visible (fused compare-and-branch).
- Latency: cond_eval at edge t gives branch_valid=1 and branch_taken=result after edge t. When cond_eval=0, branch_valid=0 and branch_taken holds its last value.
- Condition codes, with f = psr_next:
  - 0000 EQ: Z=1
  - 0001 NE: Z=0
  - 0010 CS: C=1
  - 0011 CC: C=0
  - 0100 HI: L=1
  - 0101 LS: L=0
  - 0110 GT: N=1
  - 0111 LE: N=0
  - 1000 FS: F=1
  - 1001 FC: F=0
  - 1010 LO: L=0 & Z=0
  - 1011 HS: L=1 | Z=1
  - 1100 LT: N=0 & Z=0
  - 1101 GE: N=1 | Z=1
  - 1110 UC: always taken
  - 1111 never taken
- Implement as a case statement with a default of not-taken; no latches.
- psr_wdata bits above REGBITS-1 are ignored. psr_rdata upper bits read 0.

Test Plan:
- Reset then LPR: reset low mid-stream with psr=5'b11111 → psr=0 and branch_valid=0 immediately. Release; psr_wr=1, psr_wdata=32'hFFFF_FFF5, en=1 → psr=5'b10101, psr_rdata=32'h0000_0015.
- Masked update: psr=5'b00000, flag_in=5'b11111, flag_we=5'b01011 → psr=5'b01011. Next cycle flag_we=0 → psr stays 5'b01011.
- Fused compare-branch: psr=0, flag_in=5'b00010 (Z), flag_we=5'b01011, cond_eval=1, cond=0000 → branch_valid=1, branch_taken=1 on the next cycle. Same stimulus with cond=0001 → branch_taken=0.
- Compound and fixed conditions, psr=5'b00000, one evaluation per cycle: LO(1010)→1, HS(1011)→0, LT(1100)→1, GE(1101)→0, UC(1110)→1, 1111→0. Then psr=5'b01000: LO→0, HS→1.
- Interrupt save/restore: psr=5'b10001 with psr_save=1 and flag_we=5'b11111, flag_in=0 → shadow=5'b10001, psr=0. Later psr_restore=1 → psr=5'b10001. With psr=5'b00011, shadow=5'b11000, assert save and restore together → psr=5'b11000, shadow=5'b00011.
- Stall: en=0 with psr_wr=1, cond_eval=1 → psr, shadow and branch_taken unchanged; branch_valid=0.
